// File: rtl/game_pkg.sv
// Shared types and constants for the 1A2B game sequencer and its scorer.
package game_pkg;

  typedef enum logic [1:0] {
    ST_SET  = 2'b00,
    ST_WAIT = 2'b01,
    ST_PLAY = 2'b10,
    ST_END  = 2'b11
  } state_e;

  localparam int NDIGITS        = 4;
  localparam int DIGIT_W        = 4;
  localparam int WORD_W         = NDIGITS * DIGIT_W;
  localparam int SPIN_STEPS_DEF = 6;

endpackage

// File: rtl/ab_scorer.sv
// Multi-cycle A/B scorer: examines one guess digit per cycle, leftmost first,
// then pulses done with the final counts; abort drops any scoring in flight.
module ab_scorer
  import game_pkg::*;
(
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [WORD_W-1:0] answer_i,
  input  logic [WORD_W-1:0] guess_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        a_o,
  output logic [2:0]        b_o
);

  localparam int IDX_W = $clog2(NDIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);

  logic [IDX_W-1:0]   idx_q;
  logic               busy_q;
  logic               done_q;
  logic [2:0]         a_q;
  logic [2:0]         b_q;
  logic [DIGIT_W-1:0] g_dig;
  logic [DIGIT_W-1:0] a_dig;
  logic               a_hit;
  logic               b_hit;

  // A B hit needs the digit elsewhere in the answer and no exact hit here,
  // so each guess digit contributes at most one point.
  always_comb begin
    g_dig = guess_i[int'(idx_q)*DIGIT_W +: DIGIT_W];
    a_dig = answer_i[int'(idx_q)*DIGIT_W +: DIGIT_W];
    a_hit = (g_dig == a_dig);
    b_hit = 1'b0;
    for (int j = 0; j < NDIGITS; j++) begin
      if (j != int'(idx_q) && answer_i[j*DIGIT_W +: DIGIT_W] == g_dig) b_hit = 1'b1;
    end
    if (a_hit) b_hit = 1'b0;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (abort_i) begin
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (start_i) begin
      idx_q  <= IDX_LAST;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        a_q <= a_q + {2'b00, a_hit};
        b_q <= b_q + {2'b00, b_hit};
        if (idx_q == '0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          idx_q <= idx_q - 1'b1;
        end
      end
    end
  end

  // Busy also covers the done cycle so a new guess cannot collide with the result.
  assign busy_o = busy_q | done_q;
  assign done_o = done_q;
  assign a_o    = a_q;
  assign b_o    = b_q;

endmodule

// File: rtl/game_seq_ctrl.sv
// 1A2B game sequencer. States: SET answer entry | WAIT spin until sw hidden |
// PLAY accept and score guesses | END hold win/lose until go with sw==0.
module game_seq_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV   = 5_000_000,
  parameter int MAX_TRIES  = 18,
  parameter int SPIN_STEPS = SPIN_STEPS_DEF
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        key_go,
  input  logic        key_clr,
  input  logic [15:0] sw,
  output logic [1:0]  state,
  output logic [15:0] answer,
  output logic [15:0] guess,
  output logic [2:0]  a_cnt,
  output logic [2:0]  b_cnt,
  output logic        score_vld,
  output logic [4:0]  tries,
  output logic [17:0] try_bar,
  output logic [2:0]  spin,
  output logic        win,
  output logic        lose
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [4:0]    TRIES_MAX = 5'(MAX_TRIES);
  localparam logic [2:0]    SPIN_LAST = 3'(SPIN_STEPS - 1);
  localparam logic [2:0]    A_ALL     = 3'(NDIGITS);
  localparam logic [17:0]   BAR_MASK  = 18'((64'd1 << MAX_TRIES) - 64'd1);

  logic go_s1_q, go_s2_q, go_prev_q;
  logic clr_s1_q, clr_s2_q, clr_prev_q;
  logic go_p, clr_p, clear_game;

  state_e         state_q, state_d;
  logic [15:0]    answer_q, answer_d;
  logic [15:0]    guess_q, guess_d;
  logic [2:0]     a_cnt_q, a_cnt_d;
  logic [2:0]     b_cnt_q, b_cnt_d;
  logic           vld_q, vld_d;
  logic [4:0]     tries_q, tries_d;
  logic [17:0]    bar_q, bar_d;
  logic [2:0]     spin_q, spin_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic           win_q, win_d;
  logic           lose_q, lose_d;

  logic           sc_start, sc_busy, sc_done;
  logic [2:0]     sc_a, sc_b;

  ab_scorer u_scorer (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .start_i  (sc_start),
    .abort_i  (clear_game),
    .answer_i (answer_q),
    .guess_i  (guess_q),
    .busy_o   (sc_busy),
    .done_o   (sc_done),
    .a_o      (sc_a),
    .b_o      (sc_b)
  );

  // Buttons idle high; falling edge of the synchronized level is one press.
  assign go_p       = go_prev_q & ~go_s2_q;
  assign clr_p      = clr_prev_q & ~clr_s2_q;
  assign clear_game = clr_p | ((state_q == ST_END) & go_p & (sw == '0));

  always_comb begin
    state_d  = state_q;
    answer_d = answer_q;
    guess_d  = guess_q;
    a_cnt_d  = a_cnt_q;
    b_cnt_d  = b_cnt_q;
    vld_d    = 1'b0;
    tries_d  = tries_q;
    bar_d    = bar_q;
    spin_d   = spin_q;
    tick_d   = tick_q;
    win_d    = win_q;
    lose_d   = lose_q;
    sc_start = 1'b0;

    if (clear_game) begin
      state_d = ST_SET;
      a_cnt_d = '0;
      b_cnt_d = '0;
      tries_d = '0;
      bar_d   = '0;
      spin_d  = '0;
      tick_d  = '0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_SET: begin
          if (go_p) begin
            answer_d = sw;
            state_d  = ST_WAIT;
            tick_d   = '0;
          end
        end
        ST_WAIT: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            spin_d = (spin_q == SPIN_LAST) ? 3'd0 : spin_q + 3'd1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
          if (sw == '0) begin
            state_d = ST_PLAY;
            spin_d  = '0;
          end
        end
        ST_PLAY: begin
          if (sc_done) begin
            a_cnt_d = sc_a;
            b_cnt_d = sc_b;
            vld_d   = 1'b1;
            if (sc_a == A_ALL) begin
              state_d = ST_END;
              win_d   = 1'b1;
            end else if (tries_q == TRIES_MAX) begin
              state_d = ST_END;
              lose_d  = 1'b1;
            end
          end else if (go_p && !sc_busy) begin
            guess_d  = sw;
            tries_d  = (tries_q == TRIES_MAX) ? tries_q : tries_q + 5'd1;
            bar_d    = {bar_q[16:0], 1'b1} & BAR_MASK;
            sc_start = 1'b1;
          end
        end
        ST_END: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      go_s1_q    <= 1'b1;
      go_s2_q    <= 1'b1;
      go_prev_q  <= 1'b1;
      clr_s1_q   <= 1'b1;
      clr_s2_q   <= 1'b1;
      clr_prev_q <= 1'b1;
      state_q    <= ST_SET;
      answer_q   <= '0;
      guess_q    <= '0;
      a_cnt_q    <= '0;
      b_cnt_q    <= '0;
      vld_q      <= 1'b0;
      tries_q    <= '0;
      bar_q      <= '0;
      spin_q     <= '0;
      tick_q     <= '0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      go_s1_q    <= key_go;
      go_s2_q    <= go_s1_q;
      go_prev_q  <= go_s2_q;
      clr_s1_q   <= key_clr;
      clr_s2_q   <= clr_s1_q;
      clr_prev_q <= clr_s2_q;
      state_q    <= state_d;
      answer_q   <= answer_d;
      guess_q    <= guess_d;
      a_cnt_q    <= a_cnt_d;
      b_cnt_q    <= b_cnt_d;
      vld_q      <= vld_d;
      tries_q    <= tries_d;
      bar_q      <= bar_d;
      spin_q     <= spin_d;
      tick_q     <= tick_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
    end
  end

  assign state     = state_q;
  assign answer    = answer_q;
  assign guess     = guess_q;
  assign a_cnt     = a_cnt_q;
  assign b_cnt     = b_cnt_q;
  assign score_vld = vld_q;
  assign tries     = tries_q;
  assign try_bar   = bar_q;
  assign spin      = spin_q;
  assign win       = win_q;
  assign lose      = lose_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed plus randomized game bench for game_seq_ctrl (TICK_DIV=4, MAX_TRIES=3).
module tb_game_seq_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int MAX_TRIES  = 3;
  localparam int SPIN_STEPS = 6;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        key_go;
  logic        key_clr;
  logic [15:0] sw;
  logic [1:0]  state;
  logic [15:0] answer;
  logic [15:0] guess;
  logic [2:0]  a_cnt;
  logic [2:0]  b_cnt;
  logic        score_vld;
  logic [4:0]  tries;
  logic [17:0] try_bar;
  logic [2:0]  spin;
  logic        win;
  logic        lose;

  int n_assert = 0;
  int n_fail   = 0;

  game_seq_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .MAX_TRIES  (MAX_TRIES),
    .SPIN_STEPS (SPIN_STEPS)
  ) dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .key_go    (key_go),
    .key_clr   (key_clr),
    .sw        (sw),
    .state     (state),
    .answer    (answer),
    .guess     (guess),
    .a_cnt     (a_cnt),
    .b_cnt     (b_cnt),
    .score_vld (score_vld),
    .tries     (tries),
    .try_bar   (try_bar),
    .spin      (spin),
    .win       (win),
    .lose      (lose)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Returns on the negedge right after the edge that acts on the press.
  task automatic press_go();
    key_go = 1'b0;
    tick(2);
    key_go = 1'b1;
    tick(1);
  endtask

  task automatic do_guess(input logic [15:0] g, input bit extra, output int lat, output int nv);
    lat = 0;
    nv  = 0;
    sw  = g;
    key_go = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      if (score_vld === 1'b1) begin
        nv++;
        if (lat == 0) lat = k;
      end
      if (k == 2) key_go = 1'b1;
      if (extra && k == 4) key_go = 1'b0;
      if (extra && k == 6) key_go = 1'b1;
    end
  endtask

  function automatic void ref_score(input logic [15:0] ans, input logic [15:0] g,
                                    output int a, output int b);
    logic [3:0] ad [4];
    logic [3:0] gd [4];
    a = 0;
    b = 0;
    for (int i = 0; i < 4; i++) begin
      ad[i] = ans[4*i +: 4];
      gd[i] = g[4*i +: 4];
    end
    for (int i = 0; i < 4; i++) begin
      if (gd[i] == ad[i]) a++;
      else begin
        bit hit = 1'b0;
        for (int j = 0; j < 4; j++) if (j != i && ad[j] == gd[i]) hit = 1'b1;
        if (hit) b++;
      end
    end
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(0, 5));
    return w;
  endfunction

  // Enters PLAY from SET with the given answer.
  task automatic start_game(input logic [15:0] ans);
    sw = ans;
    press_go();
    tick(3);
    sw = 16'h0000;
    tick(1);
  endtask

  initial begin
    int lat, nv, ea, eb, nt;
    logic [15:0] ans, g;
    bit ew, el;

    rst_n = 1'b0; key_go = 1'b1; key_clr = 1'b1; sw = 16'h0000;
    tick(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_tries", 32'(tries), 32'd0);
    chk("rst_bar", 32'(try_bar), 32'd0);
    chk("rst_vld", 32'(score_vld), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // SET -> WAIT, spinner cadence
    sw = 16'h1234;
    press_go();
    chk("wait_state", 32'(state), 32'd1);
    chk("wait_answer", 32'(answer), 32'h1234);
    chk("spin_n0", 32'(spin), 32'd0);
    for (int n = 1; n <= 30; n++) begin
      tick(1);
      chk($sformatf("spin_n%0d", n), 32'(spin), 32'((n / TICK_DIV) % SPIN_STEPS));
    end
    sw = 16'h5555;
    press_go();
    tick(3);
    chk("wait_go_ignored_state", 32'(state), 32'd1);
    chk("wait_go_ignored_answer", 32'(answer), 32'h1234);
    sw = 16'h0000;
    tick(1);
    chk("play_state", 32'(state), 32'd2);
    chk("play_spin", 32'(spin), 32'd0);

    // Partial score with an ignored second press while busy
    do_guess(16'h1243, 1'b1, lat, nv);
    chk("part_latency", 32'(lat), 32'd8);
    chk("part_vld_count", 32'(nv), 32'd1);
    chk("part_a", 32'(a_cnt), 32'd2);
    chk("part_b", 32'(b_cnt), 32'd2);
    chk("part_tries", 32'(tries), 32'd1);
    chk("part_bar", 32'(try_bar), 32'h1);
    chk("part_state", 32'(state), 32'd2);

    // Win, then return to SET
    do_guess(16'h1234, 1'b0, lat, nv);
    chk("win_a", 32'(a_cnt), 32'd4);
    chk("win_b", 32'(b_cnt), 32'd0);
    chk("win_state", 32'(state), 32'd3);
    chk("win_flag", 32'(win), 32'd1);
    chk("win_lose", 32'(lose), 32'd0);
    chk("win_tries", 32'(tries), 32'd2);
    chk("win_bar", 32'(try_bar), 32'h3);
    sw = 16'h0000;
    press_go();
    tick(3);
    chk("ret_state", 32'(state), 32'd0);
    chk("ret_tries", 32'(tries), 32'd0);
    chk("ret_bar", 32'(try_bar), 32'd0);
    chk("ret_a", 32'(a_cnt), 32'd0);
    chk("ret_win", 32'(win), 32'd0);
    chk("ret_answer", 32'(answer), 32'h1234);

    // Lose at the try limit
    start_game(16'h1234);
    chk("lose_play", 32'(state), 32'd2);
    for (int t = 1; t <= MAX_TRIES; t++) begin
      do_guess(16'h5678, 1'b0, lat, nv);
      chk($sformatf("lose_a%0d", t), 32'(a_cnt), 32'd0);
      chk($sformatf("lose_b%0d", t), 32'(b_cnt), 32'd0);
      chk($sformatf("lose_tries%0d", t), 32'(tries), 32'(t));
    end
    chk("lose_state", 32'(state), 32'd3);
    chk("lose_flag", 32'(lose), 32'd1);
    chk("lose_win", 32'(win), 32'd0);
    chk("lose_bar", 32'(try_bar), 32'h7);
    sw = 16'h5678;
    press_go();
    tick(3);
    chk("end_go_ignored_state", 32'(state), 32'd3);
    chk("end_go_ignored_tries", 32'(tries), 32'd3);
    sw = 16'h0000;
    press_go();
    tick(3);
    chk("lose_ret_state", 32'(state), 32'd0);

    // Randomized games against the reference scorer
    for (int gm = 0; gm < 8; gm++) begin
      ans = rand_word();
      if (ans == 16'h0000) ans = 16'h0012;
      start_game(ans);
      chk($sformatf("rg%0d_play", gm), 32'(state), 32'd2);
      nt = 0;
      ew = 1'b0;
      el = 1'b0;
      while (!ew && !el && nt < MAX_TRIES) begin
        g = ($urandom_range(0, 3) == 0) ? ans : rand_word();
        do_guess(g, 1'b0, lat, nv);
        nt++;
        ref_score(ans, g, ea, eb);
        ew = (ea == 4);
        el = !ew && (nt == MAX_TRIES);
        chk($sformatf("rg%0d_g%0d_lat", gm, nt), 32'(lat), 32'd8);
        chk($sformatf("rg%0d_g%0d_a", gm, nt), 32'(a_cnt), 32'(ea));
        chk($sformatf("rg%0d_g%0d_b", gm, nt), 32'(b_cnt), 32'(eb));
        chk($sformatf("rg%0d_g%0d_tries", gm, nt), 32'(tries), 32'(nt));
        chk($sformatf("rg%0d_g%0d_bar", gm, nt), 32'(try_bar), 32'((1 << nt) - 1));
        chk($sformatf("rg%0d_g%0d_state", gm, nt), 32'(state), (ew || el) ? 32'd3 : 32'd2);
        chk($sformatf("rg%0d_g%0d_win", gm, nt), 32'(win), 32'(ew));
        chk($sformatf("rg%0d_g%0d_lose", gm, nt), 32'(lose), 32'(el));
      end
      sw = 16'h0000;
      press_go();
      tick(3);
      chk($sformatf("rg%0d_ret", gm), 32'(state), 32'd0);
    end

    // Abort two cycles into scoring
    start_game(16'h1234);
    sw = 16'hABCD;
    key_go = 1'b0;
    nv = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      if (score_vld === 1'b1) nv++;
      if (k == 4) chk("abort_pre_state", 32'(state), 32'd2);
      if (k == 5) chk("abort_post_state", 32'(state), 32'd0);
      if (k == 2) begin
        key_go  = 1'b1;
        key_clr = 1'b0;
      end
      if (k == 4) key_clr = 1'b1;
    end
    chk("abort_no_vld", 32'(nv), 32'd0);
    chk("abort_tries", 32'(tries), 32'd0);
    chk("abort_bar", 32'(try_bar), 32'd0);
    chk("abort_guess", 32'(guess), 32'hABCD);
    chk("abort_answer", 32'(answer), 32'h1234);

    // Simultaneous go and clr in SET
    sw = 16'h9999;
    key_go = 1'b0;
    key_clr = 1'b0;
    tick(2);
    key_go = 1'b1;
    key_clr = 1'b1;
    tick(4);
    chk("both_state", 32'(state), 32'd0);
    chk("both_answer", 32'(answer), 32'h1234);

    // Asynchronous reset mid-PLAY
    start_game(16'h1234);
    do_guess(16'h5678, 1'b0, lat, nv);
    do_guess(16'h2134, 1'b0, lat, nv);
    chk("pre_rst_tries", 32'(tries), 32'd2);
    chk("pre_rst_a", 32'(a_cnt), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_tries", 32'(tries), 32'd0);
    chk("arst_bar", 32'(try_bar), 32'd0);
    chk("arst_a", 32'(a_cnt), 32'd0);
    chk("arst_b", 32'(b_cnt), 32'd0);
    chk("arst_win_lose", 32'({win, lose}), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
